// File: rtl/zoran_recv_arb.sv
// Round-robin receive-address arbiter with a registered Avalon-MM read/pop interface.
// Optional interrupt output and enable register are built when RECV_ARB_IRQ_EN is defined.
module zoran_recv_arb #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               address,
   input  logic                     write,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   output logic [NUM_CH-1:0]        ch_ready
`ifdef RECV_ARB_IRQ_EN
   ,
   output logic                     irq
`endif
);

   typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

   state_t            state_q, state_d;
   logic [2:0]        grant_q, grant_d;
   logic [2:0]        rr_ptr_q, rr_ptr_d;
   logic [2:0]        src_q, src_d;
   logic [ADDR_W-1:0] held_addr_q, held_addr_d;
   logic              pending_q, pending_d;
   logic [31:0]       readdata_q, readdata_d;

   logic [2:0]        pick_idx;
   logic              pick_found;
   logic [NUM_CH-1:0] grant_onehot;
   logic              grant_hit;
   logic              pop_req;
   int                cand;

`ifdef RECV_ARB_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;
`endif

   // Scan downward so the candidate closest to rr_ptr is the last one to overwrite the pick.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      cand       = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         cand = (int'(rr_ptr_q) + k) % NUM_CH;
         if (|((ch_valid >> cand) & NUM_CH'(1))) begin
            pick_found = 1'b1;
            pick_idx   = 3'(cand);
         end
      end
   end

   assign grant_onehot = NUM_CH'(1) << grant_q;
   assign grant_hit    = |(ch_valid & grant_onehot);
   assign pop_req      = write && (address == 2'd2) && writedata[0];
   assign ch_ready     = (state_q == ARB) ? grant_onehot : '0;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      src_d       = src_q;
      held_addr_d = held_addr_q;
      pending_d   = pending_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = ARB;
            end
         end
         ARB: begin
            if (grant_hit) begin
               held_addr_d = ADDR_W'(ch_addr >> (int'(grant_q) * ADDR_W));
               src_d       = grant_q;
               pending_d   = 1'b1;
               rr_ptr_d    = (int'(grant_q) == NUM_CH - 1) ? 3'd0 : grant_q + 3'd1;
               state_d     = HOLD;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (pop_req) begin
               pending_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      readdata_d = 32'd0;
      case (address)
         2'd0: readdata_d = 32'(held_addr_q);
         2'd1: readdata_d = 32'(pending_q) | (32'(src_q) << 8) | (32'(ch_valid) << 16);
`ifdef RECV_ARB_IRQ_EN
         2'd3: readdata_d = 32'(irq_en_q);
`endif
         default: readdata_d = 32'd0;
      endcase
   end

`ifdef RECV_ARB_IRQ_EN
   always_comb begin
      irq_en_d = irq_en_q;
      if (write && (address == 2'd3)) irq_en_d = writedata[0];
      irq_d = pending_q & irq_en_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= 3'd0;
         rr_ptr_q    <= 3'd0;
         src_q       <= 3'd0;
         held_addr_q <= '0;
         pending_q   <= 1'b0;
         readdata_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         src_q       <= src_d;
         held_addr_q <= held_addr_d;
         pending_q   <= pending_d;
         readdata_q  <= readdata_d;
      end
   end

   assign readdata = readdata_q;

endmodule
